// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_decoder
// Description : Measures high time and period (in clk cycles) of an
//               asynchronous PWM line once per period, and flags a dead line
//               (stuck high or low) with a sticky timeout.
//               Optional macro GLITCH_FILT_EN adds a FILT_LEN-cycle stability
//               filter in front of edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_decoder #(
  parameter int CNT_W    = 12,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_vld,
  output logic             timeout,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             lvl;
  logic             rise, fall;
  logic [CNT_W-1:0] hcnt, pcnt, wcnt;
  logic [CNT_W-1:0] hcnt_nxt, pcnt_nxt, wcnt_nxt;
  logic [CNT_W-1:0] high_time_nxt, period_nxt;
  logic             meas_vld_nxt, timeout_nxt, stuck_lvl_nxt;

  // Counters hold at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_CNT) ? v : v + ONE;
  endfunction

  // Two-flop synchronizer; keeps running even while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef GLITCH_FILT_EN
  logic       flt;
  logic [3:0] fcnt;

  // Adopt a new level only after s2 has differed from it for FILT_LEN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt  <= 1'b0;
      fcnt <= 4'd0;
    end else if (s2 == flt) begin
      fcnt <= 4'd0;
    end else if (fcnt == 4'(FILT_LEN - 1)) begin
      flt  <= s2;
      fcnt <= 4'd0;
    end else begin
      fcnt <= fcnt + 4'd1;
    end
  end

  assign lvl = flt;
`else
  // FILT_LEN only matters when the glitch filter is built in.
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN > 0);
  assign lvl = s2;
`endif

  // Edge flop: rising and falling edges see the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3 <= 1'b0;
    else        s3 <= lvl;
  end

  assign rise = lvl & ~s3;
  assign fall = ~lvl & s3;

  // State, counters and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hcnt      <= '0;
      pcnt      <= '0;
      wcnt      <= '0;
      high_time <= '0;
      period    <= '0;
      meas_vld  <= 1'b0;
      timeout   <= 1'b0;
      stuck_lvl <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      pcnt      <= pcnt_nxt;
      wcnt      <= wcnt_nxt;
      high_time <= high_time_nxt;
      period    <= period_nxt;
      meas_vld  <= meas_vld_nxt;
      timeout   <= timeout_nxt;
      stuck_lvl <= stuck_lvl_nxt;
    end
  end

  // Next-state logic: measure per period, publish on each rise in LOW.
  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    pcnt_nxt      = pcnt;
    wcnt_nxt      = '0;
    high_time_nxt = high_time;
    period_nxt    = period;
    meas_vld_nxt  = 1'b0;
    timeout_nxt   = timeout;
    stuck_lvl_nxt = stuck_lvl;

    if (!en) begin
      state_nxt = IDLE;
      hcnt_nxt  = '0;
      pcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt_nxt = '0;
          pcnt_nxt = '0;
          if (rise) begin
            // First edge only arms the measurement; nothing to publish yet.
            state_nxt = HIGH;
            hcnt_nxt  = ONE;
            pcnt_nxt  = ONE;
          end else if (wcnt == MAX_CNT) begin
            timeout_nxt   = 1'b1;
            stuck_lvl_nxt = lvl;
          end else begin
            wcnt_nxt = wcnt + ONE;
          end
        end
        HIGH: begin
          if (pcnt == MAX_CNT) begin
            state_nxt     = IDLE;
            hcnt_nxt      = '0;
            pcnt_nxt      = '0;
            timeout_nxt   = 1'b1;
            stuck_lvl_nxt = lvl;
          end else if (fall) begin
            state_nxt = LOW;
            pcnt_nxt  = sat_inc(pcnt);
          end else begin
            hcnt_nxt = sat_inc(hcnt);
            pcnt_nxt = sat_inc(pcnt);
          end
        end
        LOW: begin
          // A rise coinciding with saturation still publishes (period=MAX_CNT).
          if (rise) begin
            high_time_nxt = hcnt;
            period_nxt    = pcnt;
            meas_vld_nxt  = 1'b1;
            timeout_nxt   = 1'b0;
            state_nxt     = HIGH;
            hcnt_nxt      = ONE;
            pcnt_nxt      = ONE;
          end else if (pcnt == MAX_CNT) begin
            state_nxt     = IDLE;
            hcnt_nxt      = '0;
            pcnt_nxt      = '0;
            timeout_nxt   = 1'b1;
            stuck_lvl_nxt = lvl;
          end else begin
            pcnt_nxt = sat_inc(pcnt);
          end
        end
        default: begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_decoder
// Description : Self-checking bench for pwm_duty_decoder. PWM waveforms are
//               built from (high, low) cycle counts; each complete period is
//               expected to publish (high, high+low).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_decoder;

  localparam int CNT_W   = 12;
  localparam int MAX_CNT = (1 << CNT_W) - 1;
`ifdef GLITCH_FILT_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_time, period;
  logic             meas_vld, timeout, stuck_lvl;

  int n_checks = 0;
  int n_pass   = 0;

  int got_ht[$];
  int got_pr[$];
  int exp_ht[$];
  int exp_pr[$];
  int vld_idx, to_idx, vld_cnt;
  bit vld_long, prev_vld;

  pwm_duty_decoder #(.CNT_W(CNT_W), .FILT_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .meas_vld  (meas_vld),
    .timeout   (timeout),
    .stuck_lvl (stuck_lvl)
  );

  always #5 clk = ~clk;

  // Hold pwm_in at lvl for n clocks, recording every published measurement.
  task automatic drive(input bit lvl, input int n);
    vld_idx = -1;
    to_idx  = -1;
    vld_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (meas_vld) begin
        got_ht.push_back(int'(high_time));
        got_pr.push_back(int'(period));
        vld_cnt++;
        if (vld_idx < 0) vld_idx = i;
        if (prev_vld) vld_long = 1'b1;
      end
      if (timeout && to_idx < 0) to_idx = i;
      prev_vld = meas_vld;
      pwm_in   = lvl;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_ht.delete(); got_pr.delete();
    exp_ht.delete(); exp_pr.delete();
    vld_long = 1'b0;
    prev_vld = 1'b0;
  endtask

  task automatic expect_period(input int h, input int l);
    exp_ht.push_back(h);
    exp_pr.push_back(h + l);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (high_time !== '0) $display("FAIL reset_high_time: got %0d want 0", high_time); else n_pass++;
    n_checks++; if (period !== '0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
    n_checks++; if (meas_vld !== 1'b0) $display("FAIL reset_meas_vld: got %b want 0", meas_vld); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    n_checks++; if (stuck_lvl !== 1'b0) $display("FAIL reset_stuck_lvl: got %b want 0", stuck_lvl); else n_pass++;
  endtask

  task automatic test_steady();
    do_reset();
    drive(0, 10);
    for (int k = 0; k < 3; k++) begin
      drive(1, 300);
      if (k == 0) begin
        n_checks++; if (vld_cnt != 0) $display("FAIL steady_first_rise: got %0d meas_vld want 0", vld_cnt); else n_pass++;
      end else begin
        n_checks++; if (vld_idx != LAT) $display("FAIL steady_latency: got %0d cycles want %0d", vld_idx, LAT); else n_pass++;
      end
      drive(0, 1748);
      expect_period(300, 1748);
    end
    drive(1, 10);
    n_checks++; if (got_ht.size() != exp_ht.size()) $display("FAIL steady_count: got %0d want %0d", got_ht.size(), exp_ht.size()); else n_pass++;
    for (int i = 0; i < exp_ht.size() && i < got_ht.size(); i++) begin
      n_checks++;
      if (got_ht[i] != exp_ht[i] || got_pr[i] != exp_pr[i])
        $display("FAIL steady_meas[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_ht[i], got_pr[i], exp_ht[i], exp_pr[i]);
      else n_pass++;
    end
    n_checks++; if (vld_long) $display("FAIL steady_pulse_width: got pulse longer than 1 cycle want 1"); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL steady_timeout: got %b want 0", timeout); else n_pass++;
  endtask

  task automatic test_duty_random();
    int hs[$];
    int ls[$];
    hs = '{1000, 64, 100, 1};
    ls = '{1048, 1984, MAX_CNT - 100, 1};
    for (int k = 0; k < 4; k++) begin
      hs.push_back(int'($urandom_range(1500, 1)));
      ls.push_back(int'($urandom_range(1500, 1)));
    end
    do_reset();
    drive(0, 10);
    foreach (hs[k]) begin
      drive(1, hs[k]);
      drive(0, ls[k]);
      expect_period(hs[k], ls[k]);
    end
    drive(1, 10);
    n_checks++; if (got_ht.size() != exp_ht.size()) $display("FAIL duty_count: got %0d want %0d", got_ht.size(), exp_ht.size()); else n_pass++;
    for (int i = 0; i < exp_ht.size() && i < got_ht.size(); i++) begin
      n_checks++;
      if (got_ht[i] != exp_ht[i] || got_pr[i] != exp_pr[i])
        $display("FAIL duty_meas[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_ht[i], got_pr[i], exp_ht[i], exp_pr[i]);
      else n_pass++;
    end
    n_checks++; if (timeout !== 1'b0) $display("FAIL duty_timeout: got %b want 0", timeout); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 10);
    drive(1, 300);
    drive(0, 1748);
    drive(1, 300);
    drive(0, 5000);
    n_checks++; if (timeout !== 1'b1) $display("FAIL dead_low_timeout: got %b want 1", timeout); else n_pass++;
    n_checks++; if (stuck_lvl !== 1'b0) $display("FAIL dead_low_stuck_lvl: got %b want 0", stuck_lvl); else n_pass++;
    n_checks++;
    if (to_idx < 0 || 300 + to_idx < MAX_CNT || 300 + to_idx > MAX_CNT + LAT)
      $display("FAIL dead_low_delay: got %0d cycles want %0d..%0d", 300 + to_idx, MAX_CNT, MAX_CNT + LAT);
    else n_pass++;
    n_checks++;
    if (high_time !== 12'd300 || period !== 12'd2048)
      $display("FAIL dead_low_hold: got (%0d,%0d) want (300,2048)", high_time, period);
    else n_pass++;
    drive(1, 5000);
    n_checks++; if (timeout !== 1'b1) $display("FAIL dead_high_timeout: got %b want 1", timeout); else n_pass++;
    n_checks++; if (stuck_lvl !== 1'b1) $display("FAIL dead_high_stuck_lvl: got %b want 1", stuck_lvl); else n_pass++;
    drive(0, 1000);
    drive(1, 500);
    n_checks++; if (timeout !== 1'b1) $display("FAIL dead_rearm_timeout: got %b want 1", timeout); else n_pass++;
    drive(0, 1548);
    drive(1, 10);
    n_checks++; if (timeout !== 1'b0) $display("FAIL dead_clear_timeout: got %b want 0", timeout); else n_pass++;
    expect_period(300, 1748);
    expect_period(500, 1548);
    n_checks++; if (got_ht.size() != exp_ht.size()) $display("FAIL dead_count: got %0d want %0d", got_ht.size(), exp_ht.size()); else n_pass++;
    for (int i = 0; i < exp_ht.size() && i < got_ht.size(); i++) begin
      n_checks++;
      if (got_ht[i] != exp_ht[i] || got_pr[i] != exp_pr[i])
        $display("FAIL dead_meas[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_ht[i], got_pr[i], exp_ht[i], exp_pr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    do_reset();
    drive(0, 10);
    drive(1, 300);
    drive(0, 1748);
    drive(1, 100);
    expect_period(300, 1748);
    en = 1'b0;
    drive(1, 100);
    n_checks++; if (vld_cnt != 0) $display("FAIL en_gap_vld: got %0d meas_vld want 0", vld_cnt); else n_pass++;
    en = 1'b1;
    drive(1, 100);
    drive(0, 1748);
    drive(1, 300);
    n_checks++; if (vld_cnt != 0) $display("FAIL en_first_rise: got %0d meas_vld want 0", vld_cnt); else n_pass++;
    drive(0, 1748);
    drive(1, 10);
    expect_period(300, 1748);
    n_checks++; if (got_ht.size() != exp_ht.size()) $display("FAIL en_count: got %0d want %0d", got_ht.size(), exp_ht.size()); else n_pass++;
    for (int i = 0; i < exp_ht.size() && i < got_ht.size(); i++) begin
      n_checks++;
      if (got_ht[i] != exp_ht[i] || got_pr[i] != exp_pr[i])
        $display("FAIL en_meas[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_ht[i], got_pr[i], exp_ht[i], exp_pr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 10);
    drive(1, 300);
    drive(0, 1748);
    drive(1, 300);
    drive(0, 500);
    n_checks++; if (high_time !== 12'd300) $display("FAIL rstmid_pre: got %0d want 300", high_time); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (high_time !== '0 || period !== '0 || meas_vld !== 1'b0 || timeout !== 1'b0 || stuck_lvl !== 1'b0)
      $display("FAIL rstmid_outputs: got (%0d,%0d,%b,%b,%b) want all 0", high_time, period, meas_vld, timeout, stuck_lvl);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_ht.delete(); got_pr.delete();
    drive(0, 10);
    drive(1, 300);
    drive(0, 1748);
    n_checks++; if (got_ht.size() != 0) $display("FAIL rstmid_first_rise: got %0d meas want 0", got_ht.size()); else n_pass++;
    drive(1, 300);
    drive(0, 1748);
    drive(1, 10);
    expect_period(300, 1748);
    expect_period(300, 1748);
    n_checks++; if (got_ht.size() != exp_ht.size()) $display("FAIL rstmid_count: got %0d want %0d", got_ht.size(), exp_ht.size()); else n_pass++;
    for (int i = 0; i < exp_ht.size() && i < got_ht.size(); i++) begin
      n_checks++;
      if (got_ht[i] != exp_ht[i] || got_pr[i] != exp_pr[i])
        $display("FAIL rstmid_meas[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_ht[i], got_pr[i], exp_ht[i], exp_pr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    drive(0, 10);
    drive(1, 300);
    drive(0, 700);
    drive(1, 2);
    drive(0, 1046);
    drive(1, 300);
    drive(0, 1748);
    drive(1, 10);
`ifdef GLITCH_FILT_EN
    expect_period(300, 1748);
`else
    expect_period(300, 700);
    expect_period(2, 1046);
`endif
    expect_period(300, 1748);
    n_checks++; if (got_ht.size() != exp_ht.size()) $display("FAIL glitch_count: got %0d want %0d", got_ht.size(), exp_ht.size()); else n_pass++;
    for (int i = 0; i < exp_ht.size() && i < got_ht.size(); i++) begin
      n_checks++;
      if (got_ht[i] != exp_ht[i] || got_pr[i] != exp_pr[i])
        $display("FAIL glitch_meas[%0d]: got (%0d,%0d) want (%0d,%0d)", i, got_ht[i], got_pr[i], exp_ht[i], exp_pr[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_random();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
